// File: rtl/fd_reg.sv
// Fetch-to-Decode pipeline register: captures the fetched PC and instruction
// each cycle, holds them while the hazard unit stalls, reloads reset values.
module fd_reg #(
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter logic [31:0] INSTR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_instr
);

  logic [31:0] d_pc_q,    d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;

  // A stall recirculates the current contents; otherwise the Fetch values advance.
  always_comb begin
    d_pc_d    = d_pc_q;
    d_instr_d = d_instr_q;
    if (!halt) begin
      d_pc_d    = f_pc;
      d_instr_d = f_instr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset branch sits inside the clocked block and
  // ahead of the stall mux, so it is synchronous and overrides halt.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d_pc_q    <= PC_RESET;
      d_instr_q <= INSTR_RESET;
    end else begin
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
    end
  end

  assign d_pc    = d_pc_q;
  assign d_instr = d_instr_q;

endmodule

// File: tb/tb_fd_reg.sv
// Directed bench for fd_reg: reset, load, stall, reset priority, reset
// glitch immunity and a back-to-back stream, all with hand-computed values.
module tb_fd_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [31:0] d_pc;
  logic [31:0] d_instr;

  int n_cmp = 0;
  int n_err = 0;

  fd_reg dut (
    .clk     (clk),
    .reset   (reset),
    .halt    (halt),
    .f_pc    (f_pc),
    .f_instr (f_instr),
    .d_pc    (d_pc),
    .d_instr (d_instr)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; halt = 1'b0; f_pc = 32'h0; f_instr = 32'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (d_pc !== 32'h0000_3000) begin
        n_err++;
        $display("FAIL reset_pc edge %0d: got %h want %h", i, d_pc, 32'h0000_3000);
      end
      n_cmp++;
      if (d_instr !== 32'h0000_0000) begin
        n_err++;
        $display("FAIL reset_instr edge %0d: got %h want %h", i, d_instr, 32'h0);
      end
    end
  endtask

  task automatic test_load();
    reset = 1'b1; halt = 1'b0; f_pc = 32'h0000_3004; f_instr = 32'h3C01_1234;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_3004) begin
      n_err++;
      $display("FAIL load_pc: got %h want %h", d_pc, 32'h0000_3004);
    end
    n_cmp++;
    if (d_instr !== 32'h3C01_1234) begin
      n_err++;
      $display("FAIL load_instr: got %h want %h", d_instr, 32'h3C01_1234);
    end
    // Mid-cycle input change must not reach the outputs before the edge.
    #2;
    f_pc = 32'hDEAD_BEEC; f_instr = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (d_pc !== 32'h0000_3004 || d_instr !== 32'h3C01_1234) begin
      n_err++;
      $display("FAIL load_midcycle: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_3004, 32'h3C01_1234);
    end
    // Restore so the stall test starts from the loaded 3004 contents.
    halt = 1'b1;
  endtask

  task automatic test_halt();
    halt = 1'b1; f_pc = 32'h0000_3008; f_instr = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (d_pc !== 32'h0000_3004 || d_instr !== 32'h3C01_1234) begin
        n_err++;
        $display("FAIL halt_hold edge %0d: got %h/%h want %h/%h", i, d_pc, d_instr,
                 32'h0000_3004, 32'h3C01_1234);
      end
    end
    halt = 1'b0;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_3008 || d_instr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL halt_release: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_3008, 32'h0);
    end
  endtask

  task automatic test_reset_over_halt();
    f_pc = 32'h0000_4444; f_instr = 32'h1234_5678; halt = 1'b0;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_4444 || d_instr !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL prio_setup: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_4444, 32'h1234_5678);
    end
    reset = 1'b0; halt = 1'b1;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_3000 || d_instr !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL reset_over_halt: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_3000, 32'h0);
    end
    // First edge after release with halt low captures normally.
    reset = 1'b1; halt = 1'b0; f_pc = 32'h0000_5550; f_instr = 32'hA5A5_5A5A;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_5550 || d_instr !== 32'hA5A5_5A5A) begin
      n_err++;
      $display("FAIL reset_release: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_5550, 32'hA5A5_5A5A);
    end
  endtask

  task automatic test_reset_glitch();
    halt = 1'b1;
    #2;
    reset = 1'b0;
    #3;
    n_cmp++;
    if (d_pc !== 32'h0000_5550 || d_instr !== 32'hA5A5_5A5A) begin
      n_err++;
      $display("FAIL glitch_during: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_5550, 32'hA5A5_5A5A);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (d_pc !== 32'h0000_5550 || d_instr !== 32'hA5A5_5A5A) begin
      n_err++;
      $display("FAIL glitch_after: got %h/%h want %h/%h", d_pc, d_instr,
               32'h0000_5550, 32'hA5A5_5A5A);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    halt = 1'b0;
    for (int k = 0; k < 16; k++) begin
      f_pc = 32'h0000_3000 + 32'(4 * k);
      f_instr = 32'(k);
      exp_pc = 32'h0000_3000 + 32'(4 * k);
      tick();
      n_cmp++;
      if (d_pc !== exp_pc || d_instr !== 32'(k)) begin
        n_err++;
        $display("FAIL stream k=%0d: got %h/%h want %h/%h", k, d_pc, d_instr,
                 exp_pc, 32'(k));
      end
    end
  endtask

  initial begin
    reset = 1'b0; halt = 1'b0; f_pc = 32'h0; f_instr = 32'h0;
    test_reset();
    test_load();
    test_halt();
    test_reset_over_halt();
    test_reset_glitch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
